// File: rtl/hgcal_input_packer.sv
// Packs a stream of raw samples into one vector of saturated Q_W-bit codes per
// frame. Frames with a misplaced or missing s_last are dropped and reported on frame_err.
module hgcal_input_packer #(
    parameter int N_FEAT = 48,
    parameter int IN_W   = 8,
    parameter int Q_W    = 2,
    parameter int SHIFT  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_FEAT*Q_W-1:0]   m_data,
    output logic                    frame_err,
    output logic [15:0]             frame_cnt
);
    localparam int IDX_W = $clog2(N_FEAT);
    localparam int CW    = (IN_W > Q_W) ? IN_W : Q_W;
    localparam int VW    = N_FEAT * Q_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [CW-1:0]    CODE_MAX = CW'({Q_W{1'b1}});

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VW-1:0]    asm_q, asm_d;
    logic [VW-1:0]    m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic [CW-1:0]    shifted;
    logic [Q_W-1:0]   code;
    logic             at_last, accept, drain, bad_frame, complete;

    assign shifted = CW'(s_data) >> SHIFT;
    assign code    = (shifted > CODE_MAX) ? CODE_MAX[Q_W-1:0] : shifted[Q_W-1:0];

    // Only the closing sample can be stalled: it is the one that needs the output register.
    assign at_last   = (idx_q == LAST_IDX);
    assign s_ready   = !at_last || !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;
    assign drain     = m_valid_q && m_ready;
    assign bad_frame = accept && (at_last ? !s_last : s_last);
    assign complete  = accept && at_last && s_last;

    always_comb begin
        idx_d       = idx_q;
        asm_d       = asm_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = bad_frame;

        if (drain) begin
            m_valid_d   = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (accept) begin
            if (bad_frame) begin
                idx_d = '0;
            end else begin
                for (int i = 0; i < N_FEAT; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        asm_d[Q_W*i +: Q_W] = code;
                    end
                end
                // A completing frame overrides the drain so the output has no bubble.
                if (complete) begin
                    idx_d     = '0;
                    m_data_d  = asm_d;
                    m_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            asm_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_hgcal_input_packer.sv
// Bench for hgcal_input_packer with N_FEAT=4, IN_W=8, Q_W=2, SHIFT=6: directed table,
// hand-written corner sequences and random traffic against a frame-level model.
module tb_hgcal_input_packer;
    localparam int N     = 4;
    localparam int IN_W  = 8;
    localparam int Q_W   = 2;
    localparam int SHIFT = 6;
    localparam int VW    = N * Q_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [IN_W-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [VW-1:0] m_data;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    hgcal_input_packer #(.N_FEAT(N), .IN_W(IN_W), .Q_W(Q_W), .SHIFT(SHIFT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Frame-level reference: codes of the frame under construction, one pending output.
    int          mdl_codes[$];
    bit          mdl_pending;
    logic [VW-1:0] mdl_vec;
    int unsigned mdl_cnt;
    bit          mdl_err;
    bit          last_acc;

    function automatic int qcode(input int d);
        int s;
        s = d >> SHIFT;
        return (s > (2**Q_W - 1)) ? (2**Q_W - 1) : s;
    endfunction

    function automatic bit mdl_ready(input bit mr);
        return (mdl_codes.size() != N - 1) || !mdl_pending || mr;
    endfunction

    function automatic logic [VW-1:0] pack_codes();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < mdl_codes.size(); i++)
            v = v | (VW'(mdl_codes[i]) << (Q_W * i));
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mdl_codes.delete();
        mdl_pending = 1'b0;
        mdl_vec     = '0;
        mdl_cnt     = 0;
        mdl_err     = 1'b0;
    endtask

    // Called at a falling edge: drive, check ready, clock once, check outputs at next falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit mr);
        bit acc;
        bit drn;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        #1;
        chk("s_ready", 32'(s_ready), 32'(mdl_ready(mr)));
        acc = v && mdl_ready(mr);
        drn = mdl_pending && mr;
        @(posedge clk);
        mdl_err = 1'b0;
        if (drn) begin
            $display("xfer vec=0x%0h cnt=%0d", mdl_vec, (mdl_cnt + 1) % 65536);
            mdl_cnt     = (mdl_cnt + 1) % 65536;
            mdl_pending = 1'b0;
        end
        if (acc) begin
            if (mdl_codes.size() == N - 1) begin
                if (l) begin
                    mdl_codes.push_back(qcode(int'(d)));
                    mdl_vec     = pack_codes();
                    mdl_pending = 1'b1;
                end else begin
                    mdl_err = 1'b1;
                end
                mdl_codes.delete();
            end else if (l) begin
                mdl_err = 1'b1;
                mdl_codes.delete();
            end else begin
                mdl_codes.push_back(qcode(int'(d)));
            end
        end
        last_acc = acc;
        @(negedge clk);
        chk("m_valid", 32'(m_valid), 32'(mdl_pending));
        if (mdl_pending) chk("m_data", 32'(m_data), 32'(mdl_vec));
        chk("frame_err", 32'(frame_err), 32'(mdl_err));
        chk("frame_cnt", 32'(frame_cnt), 32'(mdl_cnt[15:0]));
    endtask

    task automatic idle(input bit mr);
        step(1'b0, 8'h00, 1'b0, mr);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic do_reset();
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          l;
        bit          mr;
        bit          ev;
        logic [7:0]  edata;
        bit          eerr;
        logic [15:0] ecnt;
    } vec_t;

    initial begin
        vec_t tbl[6];
        tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hE4, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        mdl_reset();
        @(negedge clk);
        do_reset();
        idle(1'b1);

        // Basic frame with final-sample latency of one cycle.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
            chk("tbl_m_valid", 32'(m_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_m_data", 32'(m_data), 32'(tbl[i].edata));
            chk("tbl_frame_err", 32'(frame_err), 32'(tbl[i].eerr));
            chk("tbl_frame_cnt", 32'(frame_cnt), 32'(tbl[i].ecnt));
        end

        // Back-to-back frames under backpressure; closing sample stalls, then drain+complete together.
        do_reset();
        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b1, 1'b0);
        chk("bp_first_vec", 32'(m_data), 32'h55);
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 8'h80, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'hFF, 1'b1, 1'b0);
            chk("bp_stall", 32'(last_acc), 32'd0);
            chk("bp_hold", 32'(m_data), 32'h55);
        end
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        chk("bp_no_bubble", 32'(m_valid), 32'd1);
        chk("bp_second_vec", 32'(m_data), 32'hCB);
        chk("bp_cnt1", 32'(frame_cnt), 32'd1);
        idle(1'b1);
        chk("bp_cnt2", 32'(frame_cnt), 32'd2);

        // Early s_last on the second sample, then a good frame.
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        chk("early_err", 32'(frame_err), 32'd1);
        idle(1'b1);
        chk("early_err_pulse", 32'(frame_err), 32'd0);
        step(1'b1, 8'h3F, 1'b0, 1'b1);
        step(1'b1, 8'h7F, 1'b0, 1'b1);
        step(1'b1, 8'hBF, 1'b0, 1'b1);
        step(1'b1, 8'hC0, 1'b1, 1'b1);
        chk("early_recover", 32'(m_data), 32'hE4);
        idle(1'b1);

        // Missing s_last: fourth sample dropped, counter unchanged, next sample starts a frame.
        for (int k = 0; k < 4; k++) step(1'b1, 8'hFF, 1'b0, 1'b1);
        chk("miss_err", 32'(frame_err), 32'd1);
        chk("miss_cnt", 32'(frame_cnt), 32'd3);
        chk("miss_no_valid", 32'(m_valid), 32'd0);
        idle(1'b1);

        // Reset mid-frame and with a pending vector.
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 8'hFF, k == 3, 1'b0);
        chk("pend_valid", 32'(m_valid), 32'd1);
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 8'(k * 64), k == 3, 1'b1);
        idle(1'b1);
        chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

        // Random traffic with occasional framing errors and backpressure.
        for (int n = 0; n < 600; n++) begin
            bit v, l, mr;
            logic [7:0] d;
            v  = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom_range(0, 255));
            mr = ($urandom_range(0, 3) != 0);
            if (mdl_codes.size() == N - 1) l = ($urandom_range(0, 9) != 0);
            else                           l = ($urandom_range(0, 19) == 0);
            step(v, d, l, mr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hgcal_input_packer.md
HGCAL_INPUT_PACKER -- requirements
Module: hgcal_input_packer

Interface
REQ-001 Parameter N_FEAT, default 48: number of input features per frame, range 2..256.
REQ-002 Parameter IN_W, default 8: unsigned width of one raw input sample.
REQ-003 Parameter Q_W, default 2: width of one quantized feature code fed to a layer0 neuron LUT.
REQ-004 Parameter SHIFT, default 6: right-shift applied before saturation, range 0..IN_W-1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 s_valid  input  1  upstream sample valid.
REQ-008 s_ready  output  1  block accepts the sample this cycle.
REQ-009 s_data  input  IN_W  raw unsigned sample.
REQ-010 s_last  input  1  marks the final sample of a frame.
REQ-011 m_valid  output  1  packed feature vector valid.
REQ-012 m_ready  input  1  downstream layer0 pipeline accepts the vector.
REQ-013 m_data  output  N_FEAT*Q_W  packed codes; feature i occupies m_data[Q_W*i +: Q_W].
REQ-014 frame_err  output  1  one-cycle pulse on a framing error.
REQ-015 frame_cnt  output  16  count of frames delivered on m, wrapping.

Function
REQ-016 A sample is accepted in a cycle when s_valid and s_ready are both 1.
REQ-017 Quantization: code = min(s_data >> SHIFT, 2^Q_W - 1), unsigned saturating, computed combinationally on acceptance.
REQ-018 A feature index counter idx (0..N_FEAT-1) selects the slot written; idx increments per accepted sample.
REQ-019 Assembly register: accepted code is written to slot idx; slots not yet written in a frame hold stale values and are never emitted.
REQ-020 Completion: a sample accepted with idx == N_FEAT-1 and s_last == 1 completes the frame; on that edge the full vector, including the final code, loads m_data, m_valid becomes 1, idx returns to 0.
REQ-021 Latency: m_valid rises on the edge that accepts the final sample (visible the following cycle).
REQ-022 s_ready = 1 when idx != N_FEAT-1; when idx == N_FEAT-1, s_ready = !m_valid || m_ready (combinational from m_ready is permitted).
REQ-023 Output hold: while m_valid && !m_ready, m_data and m_valid remain stable.
REQ-024 m_valid clears on the edge where m_valid && m_ready, unless a new frame completes on the same edge, in which case m_valid stays 1 and m_data takes the new vector.
REQ-025 frame_cnt increments by 1 (mod 2^16) on each edge where m_valid && m_ready.
REQ-026 Early s_last (s_last == 1 at idx < N_FEAT-1): sample discarded, idx -> 0, frame_err pulses, m unaffected.
REQ-027 Missing s_last (idx == N_FEAT-1 and s_last == 0): sample discarded, idx -> 0, frame_err pulses, m unaffected.
REQ-028 frame_err is registered, 1 for exactly one cycle per error event, 0 otherwise.
REQ-029 No sample is dropped or duplicated except as in REQ-026/027.

Reset
REQ-030 On rst_n low: idx = 0, m_valid = 0, m_data = 0, frame_err = 0, frame_cnt = 0, immediately and asynchronously.
REQ-031 Reset mid-frame discards the partial frame; reset with m_valid = 1 discards the pending vector without counting it.
REQ-032 Reset deassertion is synchronized by the integrator; the first accepted sample after release is treated as idx 0.

Verification (N_FEAT=4, IN_W=8, Q_W=2, SHIFT=6)
REQ-033 Samples 0x00,0x40,0x80,0xFF with s_last on 4th, m_ready=1 -> m_valid one cycle later, m_data = 8'b11100100, frame_cnt = 1.
REQ-034 m_ready=0, send two full frames back-to-back -> second frame's last sample stalls (s_ready=0) until m_ready=1; both vectors delivered in order, frame_cnt = 2.
REQ-035 Simultaneous drain and completion (m_valid=1, m_ready=1, final sample accepted) -> m_valid stays 1, m_data switches to new vector next cycle, no bubble.
REQ-036 s_last on 2nd sample -> frame_err 1 for one cycle, no m_valid; following valid 4-sample frame delivers correctly.
REQ-037 4th sample without s_last -> frame_err pulse, idx = 0; frame_cnt unchanged.
REQ-038 rst_n low after 2 samples and again with m_valid=1 pending -> all outputs 0 immediately; next full frame delivered with frame_cnt = 1.
